hilo_exec: RTL and testbench
============================

HILO_EXEC -- requirements
Module: hilo_exec

Interface
REQ-001 SHALL: one clock; reset is asynchronous and active-low.
REQ-002 SHALL: clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL: rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL: in_valid, input, 1, EX-stage instruction valid; held asserted with identical operands while stallreq=1.
REQ-005 SHALL: hilo_op, input, 9, one-hot {mfhi,mflo,mthi,mtlo,mult,multu,div,divu,mul}, same bit order as the decoder output.
REQ-006 SHALL: src1, input, 32, rs value (dividend / multiplicand / mthi-mtlo data).
REQ-007 SHALL: src2, input, 32, rt value (divisor / multiplier).
REQ-008 SHALL: flush, input, 1, exception/eret flush of the EX instruction.
REQ-009 SHALL: stallreq, output, 1, pipeline hold request.
REQ-010 SHALL: rf_wdata, output, 32, GPR result for mfhi/mflo/mul.
REQ-011 SHALL: hi_o, lo_o, output, 32 each, current HI/LO register values.

Function
REQ-012 SHALL: FSM states IDLE, MUL, DIV, DONE; encoding comes from the shared package.
REQ-013 SHALL: in IDLE with in_valid&~flush&(mult|multu|mul|div|divu), drive stallreq=1 combinationally and latch operands and op.
- mult/multu/mul go to MUL.
- div/divu with src2!=0 go to DIV.
REQ-014 SHALL: MUL lasts 1 cycle.
- Registers the 64-bit product: signed for mult/mul, unsigned for multu.
- Goes to DONE; stallreq=1.
REQ-015 SHALL: DIV lasts exactly 32 cycles, one restoring radix-2 step per cycle, on magnitudes for div and raw values for divu; stallreq=1 throughout.
- A 5-bit counter counts 0..31.
- On count 31, go to DONE.
REQ-016 SHALL: in DONE, drive stallreq=0 for one cycle and return to IDLE.
- mult/multu/div/divu: write HI/LO at the end of this cycle.
- mul: drive rf_wdata=product[31:0] and leave HI/LO unchanged.
- in_valid remaining high in DONE SHALL NOT restart the unit.
REQ-017 SHALL: mult/multu write HI=product[63:32] and LO=product[31:0].
REQ-018 SHALL: div/divu write LO=quotient and HI=remainder.
- Quotient is negative iff operand signs differ.
- Remainder takes the dividend's sign.
- 0x80000000 div 0xFFFFFFFF gives LO=0x80000000, HI=0.
REQ-019 SHALL: div/divu with src2==0 completes in one cycle with stallreq=0 and HI/LO unchanged.
REQ-020 SHALL: mthi/mtlo write src1 into HI or LO at the end of the issuing cycle, with no stall.
REQ-021 SHALL: mfhi/mflo drive rf_wdata = registered HI or LO combinationally.
- No internal bypass; a write becomes visible the next cycle.
REQ-022 SHALL: flush in any state returns the FSM to IDLE next cycle, drives stallreq=0 in that cycle, suppresses any HI/LO write, and discards partial results.
REQ-023 SHALL: rf_wdata=0 whenever the current op is not mfhi/mflo/mul-in-DONE.
REQ-024 SHALL: flush has priority over new issue and over completion when both occur in the same cycle.

Reset
REQ-025 SHALL: reset assertion immediately forces state=IDLE, HI=LO=0, counter=0, operand/product registers=0, and stallreq=0.
REQ-026 SHALL: reset mid-operation abandons the operation with no HI/LO update after deassertion.

Structure
REQ-027 SHALL: the shared package holds the hilo_op bit-index constants (HILO_MFHI=8 .. HILO_MUL=0), the FSM state typedef, and DIV_STEPS=32.
REQ-028 SHALL: the iterative divider datapath (step register, partial remainder, counter) is one sub-module, div_radix2.
- hilo_exec owns the FSM, the HI/LO registers, the multiplier and sign correction.

Verification
REQ-029 SHALL: mult src1=0xFFFFFFFE, src2=0x00000003 -> stall 2 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-030 SHALL: divu src1=100, src2=7 -> stallreq high 33 cycles, then LO=14, HI=2.
REQ-031 SHALL: div src1=0xFFFFFFF9 (-7), src2=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-032 SHALL: mul src1=0x00010000, src2=0x00010001 -> rf_wdata=0x00010000 in DONE, HI/LO unchanged.
REQ-033 SHALL: mthi 0xDEADBEEF, then mfhi the next cycle -> rf_wdata=0xDEADBEEF, no stall.
REQ-034 SHALL: divu started, flush at DIV cycle 10 -> stallreq=0 that cycle, IDLE next cycle, HI/LO hold their prior values; a repeat with rst pulsed low gives HI=LO=0.

Source files
------------

// File: rtl/hilo_exec_pkg.sv
// Purpose: shared constants and types for the HI/LO multiply-divide execution unit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package hilo_exec_pkg;

    // hilo_op is one-hot, same bit order as the decoder:
    // {mfhi, mflo, mthi, mtlo, mult, multu, div, divu, mul}
    localparam int HILO_W     = 9;
    localparam int HILO_MFHI  = 8;
    localparam int HILO_MFLO  = 7;
    localparam int HILO_MTHI  = 6;
    localparam int HILO_MTLO  = 5;
    localparam int HILO_MULT  = 4;
    localparam int HILO_MULTU = 3;
    localparam int HILO_DIV   = 2;
    localparam int HILO_DIVU  = 1;
    localparam int HILO_MUL   = 0;

    // One restoring step per cycle, one quotient bit per step.
    localparam int DIV_STEPS = 32;
    localparam int DIV_CNT_W = $clog2(DIV_STEPS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } hilo_state_t;

    // Magnitude of a 32-bit value when treated as signed; raw value otherwise.
    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_radix2.sv
// Purpose: iterative unsigned restoring radix-2 divider datapath (quotient, partial remainder, step counter).
// Latency: one quotient bit per step; DIV_STEPS steps after load; last flags the final step.
// Backpressure: none; the owner issues load/step/abort and decides when results are consumed.
// Ports: clk/rst; load latches dividend/divisor magnitudes, step performs one iteration,
//        abort clears all state; quotient/remainder are valid after the last step; last is
//        high while the counter sits on the final step.
module div_radix2
    import hilo_exec_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic        abort,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        last
);

    // quo_q starts as the dividend and shifts left; quotient bits enter at the bottom.
    logic [31:0]          quo_q;
    logic [31:0]          rem_q;
    logic [31:0]          dvs_q;
    logic [DIV_CNT_W-1:0] cnt_q;

    logic [32:0] shifted;
    logic [32:0] trial;

    // rem_q < divisor always holds, so shifted < 2*divisor and trial's top bit
    // is set exactly when the subtraction would go negative.
    always_comb begin
        shifted = {rem_q, quo_q[31]};
        trial   = shifted - {1'b0, dvs_q};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (abort) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            quo_q <= dividend;
            rem_q <= '0;
            dvs_q <= divisor;
            cnt_q <= '0;
        end else if (step) begin
            if (!trial[32]) begin
                rem_q <= trial[31:0];
                quo_q <= {quo_q[30:0], 1'b1};
            end else begin
                rem_q <= shifted[31:0];
                quo_q <= {quo_q[30:0], 1'b0};
            end
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign last      = (cnt_q == DIV_CNT_W'(DIV_STEPS - 1));

endmodule

// File: rtl/hilo_exec.sv
// Purpose: EX-stage HI/LO unit: mult/multu/mul, div/divu, mthi/mtlo, mfhi/mflo.
// Latency: mul ops stall 2 cycles, div ops stall 33 cycles, then one non-stalled DONE cycle; others 0.
// Backpressure: stallreq holds the pipeline; in_valid/operands must stay stable while it is high.
// Ports: clk, rst (async active-low); in_valid, hilo_op (one-hot), src1 (rs), src2 (rt), flush;
//        stallreq, rf_wdata (mfhi/mflo/mul result), hi_o, lo_o (architectural HI/LO).
module hilo_exec
    import hilo_exec_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [HILO_W-1:0] hilo_op,
    input  logic [31:0]       src1,
    input  logic [31:0]       src2,
    input  logic              flush,
    output logic              stallreq,
    output logic [31:0]       rf_wdata,
    output logic [31:0]       hi_o,
    output logic [31:0]       lo_o
);

    hilo_state_t state_q;

    // Latched instruction class for the multi-cycle ops.
    logic k_mul_rf_q;   // mul: result to GPR, HI/LO untouched
    logic k_mult_q;     // mult/multu: product to HI/LO
    logic k_div_q;      // div/divu: quotient/remainder to LO/HI
    logic k_signed_q;   // mult, mul, div

    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [63:0] prod_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        act;
    logic        is_mulop;
    logic        is_divop;
    logic        issue_mul;
    logic        issue_div;
    logic        op_signed;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;
    logic [31:0] div_quo;
    logic [31:0] div_rem;
    logic        div_last;
    logic        q_neg;
    logic        r_neg;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    always_comb begin
        // Reset gates issue so stallreq is forced low while rst is asserted.
        act       = rst & in_valid & ~flush & (state_q == ST_IDLE);
        is_mulop  = hilo_op[HILO_MULT] | hilo_op[HILO_MULTU] | hilo_op[HILO_MUL];
        is_divop  = hilo_op[HILO_DIV] | hilo_op[HILO_DIVU];
        issue_mul = act & is_mulop;
        // Divide by zero never enters the FSM: no stall, HI/LO untouched.
        issue_div = act & is_divop & (src2 != 32'd0);
        op_signed = hilo_op[HILO_MULT] | hilo_op[HILO_MUL] | hilo_op[HILO_DIV];
    end

    assign stallreq = ~flush & (issue_mul | issue_div |
                                (state_q == ST_MUL) | (state_q == ST_DIV));

    // Sign-extend to 64 bits for signed ops so the low 64 bits of the product are exact.
    always_comb begin
        mul_a   = {{32{k_signed_q & a_q[31]}}, a_q};
        mul_b   = {{32{k_signed_q & b_q[31]}}, b_q};
        product = mul_a * mul_b;
    end

    div_radix2 u_div (
        .clk       (clk),
        .rst       (rst),
        .load      (issue_div),
        .step      ((state_q == ST_DIV) & ~flush),
        .abort     (flush),
        .dividend  (mag32(src1, hilo_op[HILO_DIV])),
        .divisor   (mag32(src2, hilo_op[HILO_DIV])),
        .quotient  (div_quo),
        .remainder (div_rem),
        .last      (div_last)
    );

    // Quotient negative iff operand signs differ; remainder follows the dividend.
    always_comb begin
        q_neg   = k_signed_q & (a_q[31] ^ b_q[31]);
        r_neg   = k_signed_q & a_q[31];
        quo_fix = q_neg ? (~div_quo + 32'd1) : div_quo;
        rem_fix = r_neg ? (~div_rem + 32'd1) : div_rem;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            k_mul_rf_q <= 1'b0;
            k_mult_q   <= 1'b0;
            k_div_q    <= 1'b0;
            k_signed_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            prod_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else if (flush) begin
            // Flush beats issue and completion: drop everything, no HI/LO write.
            state_q <= ST_IDLE;
            prod_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (issue_mul || issue_div) begin
                        state_q    <= issue_mul ? ST_MUL : ST_DIV;
                        k_mul_rf_q <= hilo_op[HILO_MUL];
                        k_mult_q   <= hilo_op[HILO_MULT] | hilo_op[HILO_MULTU];
                        k_div_q    <= is_divop;
                        k_signed_q <= op_signed;
                        a_q        <= src1;
                        b_q        <= src2;
                    end
                    if (act && hilo_op[HILO_MTHI]) hi_q <= src1;
                    if (act && hilo_op[HILO_MTLO]) lo_q <= src1;
                end
                ST_MUL: begin
                    prod_q  <= product;
                    state_q <= ST_DONE;
                end
                ST_DIV: begin
                    if (div_last) state_q <= ST_DONE;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    if (k_mult_q) begin
                        hi_q <= prod_q[63:32];
                        lo_q <= prod_q[31:0];
                    end else if (k_div_q) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // mfhi/mflo read the registered values: no bypass of a same-cycle write.
    always_comb begin
        rf_wdata = '0;
        if (state_q == ST_DONE) begin
            if (k_mul_rf_q && !flush) rf_wdata = prod_q[31:0];
        end else if (state_q == ST_IDLE && in_valid) begin
            if (hilo_op[HILO_MFHI])      rf_wdata = hi_q;
            else if (hilo_op[HILO_MFLO]) rf_wdata = lo_q;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_hilo_exec.sv
// Purpose: self-checking bench for hilo_exec against a high-level arithmetic reference model.
// Latency: observes stall counts per instruction and HI/LO after each completion.
// Backpressure: holds in_valid/operands stable while stallreq is high, as the pipeline would.
module tb_hilo_exec;

    localparam logic [8:0] OP_MFHI  = 9'h100;
    localparam logic [8:0] OP_MFLO  = 9'h080;
    localparam logic [8:0] OP_MTHI  = 9'h040;
    localparam logic [8:0] OP_MTLO  = 9'h020;
    localparam logic [8:0] OP_MULT  = 9'h010;
    localparam logic [8:0] OP_MULTU = 9'h008;
    localparam logic [8:0] OP_DIV   = 9'h004;
    localparam logic [8:0] OP_DIVU  = 9'h002;
    localparam logic [8:0] OP_MUL   = 9'h001;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [8:0]  hilo_op = '0;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic        flush = 1'b0;
    logic        stallreq;
    logic [31:0] rf_wdata;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int errors = 0;
    int checks = 0;

    // Architectural HI/LO as the model sees them.
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    hilo_exec dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .hilo_op  (hilo_op),
        .src1     (src1),
        .src2     (src2),
        .flush    (flush),
        .stallreq (stallreq),
        .rf_wdata (rf_wdata),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    // Reference: MIPS HI/LO semantics via 64-bit arithmetic, plus expected stall length.
    task automatic ref_model(input logic [8:0] op, input logic [31:0] a, input logic [31:0] b,
                             output int exp_stalls, output logic [31:0] exp_rf);
        longint      sa, sb, sp, sq, sr;
        logic [63:0] up;
        exp_stalls = 0;
        exp_rf     = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_MFHI: exp_rf = m_hi;
            OP_MFLO: exp_rf = m_lo;
            OP_MTHI: m_hi = a;
            OP_MTLO: m_lo = a;
            OP_MULT: begin
                sp = sa * sb;
                m_hi = sp[63:32];
                m_lo = sp[31:0];
                exp_stalls = 2;
            end
            OP_MULTU: begin
                up = {32'd0, a} * {32'd0, b};
                m_hi = up[63:32];
                m_lo = up[31:0];
                exp_stalls = 2;
            end
            OP_MUL: begin
                sp = sa * sb;
                exp_rf = sp[31:0];
                exp_stalls = 2;
            end
            OP_DIV: if (b != 0) begin
                sq = sa / sb;
                sr = sa % sb;
                m_lo = sq[31:0];
                m_hi = sr[31:0];
                exp_stalls = 33;
            end
            OP_DIVU: if (b != 0) begin
                m_lo = a / b;
                m_hi = a % b;
                exp_stalls = 33;
            end
            default: ;
        endcase
    endtask

    // Issue one instruction, hold it while stalled, optionally flush at stall index
    // flush_at (0 = issue cycle). Returns stall count, rf_wdata in the final cycle,
    // and HI/LO just after the final edge.
    task automatic do_op(input logic [8:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int flush_at, output int stalls, output logic [31:0] rf,
                         output logic [31:0] hi_s, output logic [31:0] lo_s);
        bit fin;
        @(negedge clk);
        in_valid = 1'b1;
        hilo_op  = op;
        src1     = a;
        src2     = b;
        stalls   = 0;
        fin      = 1'b0;
        rf       = '0;
        while (!fin) begin
            flush = (stalls == flush_at);
            #1;
            if (!stallreq || stalls >= 60) begin
                fin = 1'b1;
                rf  = rf_wdata;
            end else begin
                stalls++;
                @(negedge clk);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        hilo_op  = '0;
        src1     = '0;
        src2     = '0;
        flush    = 1'b0;
        hi_s = hi_o;
        lo_s = lo_o;
    endtask

    task automatic test_reset();
        in_valid = 1'b1;
        hilo_op  = OP_MULT;
        src1     = 32'h5;
        src2     = 32'h7;
        repeat (3) @(negedge clk);
        checks++;
        if (stallreq !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stallreq); end
        checks++;
        if (hi_o !== 32'h0 || lo_o !== 32'h0) begin
            errors++; $display("FAIL reset_hilo: got %h/%h expected 0/0", hi_o, lo_o);
        end
        in_valid = 1'b0;
        hilo_op  = '0;
        #1;
        checks++;
        if (rf_wdata !== 32'h0) begin errors++; $display("FAIL reset_rf: got %h expected 0", rf_wdata); end
        rst = 1'b1;
        m_hi = '0;
        m_lo = '0;
    endtask

    typedef struct {
        logic [8:0]  op;
        logic [31:0] a, b;
        int          st;
        logic [31:0] rf, hi, lo;
    } vec_t;

    task automatic test_vectors();
        vec_t v[10];
        int st;
        logic [31:0] rf, h, l, erf;
        int est;
        v[0] = '{OP_MULT,  32'hFFFFFFFE, 32'h00000003,  2, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFA};
        v[1] = '{OP_MUL,   32'h00010000, 32'h00010001,  2, 32'h00010000, 32'hFFFFFFFF, 32'hFFFFFFFA};
        v[2] = '{OP_DIVU,  32'd100,      32'd7,        33, 32'h0,        32'd2,        32'd14};
        v[3] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        33, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD};
        v[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 33, 32'h0,        32'h0,        32'h80000000};
        v[5] = '{OP_DIVU,  32'd5,        32'd0,         0, 32'h0,        32'h0,        32'h80000000};
        v[6] = '{OP_MTHI,  32'hDEADBEEF, 32'h0,         0, 32'h0,        32'hDEADBEEF, 32'h80000000};
        v[7] = '{OP_MFHI,  32'h0,        32'h0,         0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h80000000};
        v[8] = '{OP_MTLO,  32'h12345678, 32'h0,         0, 32'h0,        32'hDEADBEEF, 32'h12345678};
        v[9] = '{OP_MFLO,  32'h0,        32'h0,         0, 32'h12345678, 32'hDEADBEEF, 32'h12345678};
        for (int i = 0; i < 10; i++) begin
            ref_model(v[i].op, v[i].a, v[i].b, est, erf);
            do_op(v[i].op, v[i].a, v[i].b, -1, st, rf, h, l);
            checks++;
            if (st !== v[i].st) begin errors++; $display("FAIL vec%0d_stall: got %0d expected %0d", i, st, v[i].st); end
            checks++;
            if (rf !== v[i].rf) begin errors++; $display("FAIL vec%0d_rf: got %h expected %h", i, rf, v[i].rf); end
            checks++;
            if (h !== v[i].hi || l !== v[i].lo) begin
                errors++; $display("FAIL vec%0d_hilo: got %h/%h expected %h/%h", i, h, l, v[i].hi, v[i].lo);
            end
        end
    endtask

    task automatic test_random(input int n);
        logic [8:0]  op;
        logic [31:0] a, b, rf, h, l, erf;
        int st, est;
        for (int i = 0; i < n; i++) begin
            op = 9'h001 << $urandom_range(0, 8);
            a  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: b = $urandom_range(1, 9);
                2: b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            ref_model(op, a, b, est, erf);
            do_op(op, a, b, -1, st, rf, h, l);
            checks++;
            if (st !== est || rf !== erf || h !== m_hi || l !== m_lo) begin
                errors++;
                $display("FAIL rand%0d op=%h a=%h b=%h: got st=%0d rf=%h hi=%h lo=%h expected st=%0d rf=%h hi=%h lo=%h",
                         i, op, a, b, st, rf, h, l, est, erf, m_hi, m_lo);
            end
        end
    endtask

    task automatic test_flush();
        logic [8:0]  fops[5];
        int          fat[5];
        logic [31:0] rf, h, l;
        int st;
        bit stalled;
        fops = '{OP_DIVU, OP_MULT, OP_MULT, OP_MUL, OP_MTHI};
        fat  = '{10, 0, 1, 2, 0};
        for (int i = 0; i < 5; i++) begin
            do_op(fops[i], 32'h00000064, 32'h00000007, fat[i], st, rf, h, l);
            checks++;
            if (st !== fat[i]) begin errors++; $display("FAIL flush%0d_stall: got %0d expected %0d", i, st, fat[i]); end
            checks++;
            if (rf !== 32'h0) begin errors++; $display("FAIL flush%0d_rf: got %h expected 0", i, rf); end
            checks++;
            if (h !== m_hi || l !== m_lo) begin
                errors++; $display("FAIL flush%0d_hilo: got %h/%h expected %h/%h", i, h, l, m_hi, m_lo);
            end
            if (i == 0) begin
                // A surviving divide would keep stalling and later write HI/LO.
                stalled = 1'b0;
                repeat (40) begin
                    @(negedge clk);
                    #1;
                    if (stallreq) stalled = 1'b1;
                end
                checks++;
                if (stalled || hi_o !== m_hi || lo_o !== m_lo) begin
                    errors++;
                    $display("FAIL flush_idle: got stall=%b hi=%h lo=%h expected stall=0 hi=%h lo=%h",
                             stalled, hi_o, lo_o, m_hi, m_lo);
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        in_valid = 1'b1;
        hilo_op  = OP_DIVU;
        src1     = 32'd100;
        src2     = 32'd7;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (stallreq !== 1'b0 || hi_o !== 32'h0 || lo_o !== 32'h0) begin
            errors++;
            $display("FAIL rst_abort_now: got stall=%b hi=%h lo=%h expected 0/0/0", stallreq, hi_o, lo_o);
        end
        in_valid = 1'b0;
        hilo_op  = '0;
        @(negedge clk);
        rst = 1'b1;
        m_hi = '0;
        m_lo = '0;
        repeat (40) @(negedge clk);
        #1;
        checks++;
        if (stallreq !== 1'b0 || hi_o !== 32'h0 || lo_o !== 32'h0) begin
            errors++;
            $display("FAIL rst_abort_after: got stall=%b hi=%h lo=%h expected 0/0/0", stallreq, hi_o, lo_o);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random(50);
        test_flush();
        test_reset_abort();
        test_random(12);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
